// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and helpers for the pipeline handshake controller
package pipe_ctrl_pkg;

  localparam logic ENABLE        = 1'b1;
  localparam logic DISABLE       = 1'b0;
  localparam logic RESET_ENABLE  = 1'b1;
  localparam int   DEFAULT_CNT_W = 32;
  localparam int   POP_W         = 64;

  // Count of set bits in a (zero-extended) valid vector
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    popcount = 0;
    for (int i = 0; i < POP_W; i++) begin
      popcount = popcount + 32'(v[i]);
    end
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - valid/allowin/load control for one pipeline stage
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic prev_vns,
  input  logic prev_kill,
  input  logic kill,
  input  logic ready_go,
  input  logic next_allowin,
  output logic valid,
  output logic vns,
  output logic allowin,
  output logic load
);

  assign vns     = valid & ready_go;
  assign allowin = !valid | (ready_go & next_allowin);
  // A killed predecessor hands over a bubble, so its datapath register is not loaded
  assign load    = prev_vns & allowin & !prev_kill;

  // Valid bit: kill beats stall, otherwise take the predecessor's offer when allowed in
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ENABLE) begin
      valid <= DISABLE;
    end else if (kill) begin
      valid <= DISABLE;
    end else if (allowin) begin
      valid <= prev_vns & !prev_kill;
    end
  end

endmodule

// File: rtl/pipe_handshake_ctrl.sv
// rtl/pipe_handshake_ctrl.sv - N-stage valid/allowin pipeline controller; macro PIPE_HANDSHAKE_PERF_EN adds perf counters
module pipe_handshake_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 5,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES-1:0] stage_ready_go,
  input  logic [STAGES-1:0] flush,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_allowin,
  output logic [STAGES-1:0] stage_load,
  output logic              out_valid,
  output logic [CNT_W-1:0]  occupancy
`ifdef PIPE_HANDSHAKE_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_retired,
  output logic [CNT_W-1:0]  perf_bubble,
  output logic [CNT_W-1:0]  perf_flush
`endif
);

  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] vns;
  logic              kill_in;

  // kill[i] is the union of every flush request from an older stage
  always_comb begin
    kill = '0;
    for (int i = STAGES - 2; i >= 0; i--) begin
      kill[i] = kill[i+1] | flush[i+1];
    end
  end

  assign kill_in   = |flush;
  assign in_ready  = stage_allowin[0] & (kill_in != ENABLE);
  assign out_valid = vns[STAGES-1];
  assign occupancy = CNT_W'(popcount(POP_W'(stage_valid)));

  // Allowin ripples from the retire port towards stage 0 through per-stage nets
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic prev_vns;
    logic prev_kill;
    logic next_allowin;
    logic allowin_w;

    if (i == 0) begin : g_first
      assign prev_vns  = in_valid;
      assign prev_kill = kill_in;
    end else begin : g_mid
      assign prev_vns  = vns[i-1];
      assign prev_kill = kill[i-1];
    end

    if (i == STAGES - 1) begin : g_last
      assign next_allowin = out_ready;
    end else begin : g_inner
      assign next_allowin = g_stage[i+1].allowin_w;
    end

    pipe_stage_ctrl u_stage (
      .clk          (clk),
      .rst          (rst),
      .prev_vns     (prev_vns),
      .prev_kill    (prev_kill),
      .kill         (kill[i]),
      .ready_go     (stage_ready_go[i]),
      .next_allowin (next_allowin),
      .valid        (stage_valid[i]),
      .vns          (vns[i]),
      .allowin      (allowin_w),
      .load         (stage_load[i])
    );

    assign stage_allowin[i] = allowin_w;
  end

`ifdef PIPE_HANDSHAKE_PERF_EN
  // Event counters: retirements, writeback bubbles, cycles with an older-stage flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RESET_ENABLE) begin
      perf_retired <= '0;
      perf_bubble  <= '0;
      perf_flush   <= '0;
    end else begin
      if (out_valid && out_ready) perf_retired <= perf_retired + CNT_W'(1);
      if (!stage_valid[STAGES-1]) perf_bubble <= perf_bubble + CNT_W'(1);
      if (|flush[STAGES-1:1])     perf_flush  <= perf_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_handshake_ctrl.sv
// tb/tb_pipe_handshake_ctrl.sv - directed vector bench for pipe_handshake_ctrl
module tb_pipe_handshake_ctrl;

  localparam int S = 5;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [S-1:0] stage_ready_go;
  logic [S-1:0] flush;
  logic         out_ready;
  logic [S-1:0] stage_valid;
  logic [S-1:0] stage_allowin;
  logic [S-1:0] stage_load;
  logic         out_valid;
  logic [31:0]  occupancy;
`ifdef PIPE_HANDSHAKE_PERF_EN
  logic [31:0]  perf_retired;
  logic [31:0]  perf_bubble;
  logic [31:0]  perf_flush;
`endif

  int tests;
  int failed;

  pipe_handshake_ctrl #(.STAGES(S), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stage_ready_go (stage_ready_go),
    .flush          (flush),
    .out_ready      (out_ready),
    .stage_valid    (stage_valid),
    .stage_allowin  (stage_allowin),
    .stage_load     (stage_load),
    .out_valid      (out_valid),
    .occupancy      (occupancy)
`ifdef PIPE_HANDSHAKE_PERF_EN
    ,
    .perf_retired   (perf_retired),
    .perf_bubble    (perf_bubble),
    .perf_flush     (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         iv;
    logic [S-1:0] rg;
    logic [S-1:0] fl;
    logic         ordy;
    logic [S-1:0] e_valid;
    logic         e_in_ready;
    logic [S-1:0] e_load;
    logic [S-1:0] e_allowin;
    logic         e_out_valid;
    int           e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [S-1:0] rg, input logic [S-1:0] fl, input logic ordy,
                     input logic [S-1:0] ev, input logic eir, input logic [S-1:0] el,
                     input logic [S-1:0] ea, input logic eov, input int eocc);
    vec_t v;
    v.iv = iv; v.rg = rg; v.fl = fl; v.ordy = ordy;
    v.e_valid = ev; v.e_in_ready = eir; v.e_load = el; v.e_allowin = ea;
    v.e_out_valid = eov; v.e_occ = eocc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [S-1:0] rg, input logic [S-1:0] fl, input logic ordy);
    in_valid = iv; stage_ready_go = rg; flush = fl; out_ready = ordy;
  endtask

`ifdef PIPE_HANDSHAKE_PERF_EN
  logic [S-1:0] mv;
  logic [S:0]   ma;
  logic [S-1:0] mk;
  logic [S-1:0] nv;
  int           exp_ret, exp_bub, exp_fl;
`endif

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    drive(1'b0, '1, '0, 1'b1);

    // stream fill
    add(1, 5'b11111, 5'b00000, 1, 5'b00000, 1, 5'b00001, 5'b11111, 0, 0);
    add(1, 5'b11111, 5'b00000, 1, 5'b00001, 1, 5'b00011, 5'b11111, 0, 1);
    add(1, 5'b11111, 5'b00000, 1, 5'b00011, 1, 5'b00111, 5'b11111, 0, 2);
    add(1, 5'b11111, 5'b00000, 1, 5'b00111, 1, 5'b01111, 5'b11111, 0, 3);
    add(1, 5'b11111, 5'b00000, 1, 5'b01111, 1, 5'b11111, 5'b11111, 0, 4);
    for (int k = 0; k < 3; k++)
      add(1, 5'b11111, 5'b00000, 1, 5'b11111, 1, 5'b11111, 5'b11111, 1, 5);
    // stage 2 stall for three cycles
    add(1, 5'b11011, 5'b00000, 1, 5'b11111, 0, 5'b10000, 5'b11000, 1, 5);
    add(1, 5'b11011, 5'b00000, 1, 5'b10111, 0, 5'b00000, 5'b11000, 1, 4);
    add(1, 5'b11011, 5'b00000, 1, 5'b00111, 0, 5'b00000, 5'b11000, 0, 3);
    add(1, 5'b11111, 5'b00000, 1, 5'b00111, 1, 5'b01111, 5'b11111, 0, 3);
    add(1, 5'b11111, 5'b00000, 1, 5'b01111, 1, 5'b11111, 5'b11111, 0, 4);
    add(1, 5'b11111, 5'b00000, 1, 5'b11111, 1, 5'b11111, 5'b11111, 1, 5);
    // retire backpressure for four cycles
    for (int k = 0; k < 4; k++)
      add(1, 5'b11111, 5'b00000, 0, 5'b11111, 0, 5'b00000, 5'b00000, 1, 5);
    // flush[3] and flush[1] together while stage 1 stalls
    add(1, 5'b11101, 5'b01010, 0, 5'b11111, 0, 5'b00000, 5'b00000, 1, 5);
    add(1, 5'b11111, 5'b00000, 1, 5'b11000, 1, 5'b10001, 5'b11111, 1, 2);
    add(1, 5'b11111, 5'b00000, 1, 5'b10001, 1, 5'b00011, 5'b11111, 1, 2);
    add(1, 5'b11111, 5'b00000, 1, 5'b00011, 1, 5'b00111, 5'b11111, 0, 2);
    add(1, 5'b11111, 5'b00000, 1, 5'b00111, 1, 5'b01111, 5'b11111, 0, 3);
    add(1, 5'b11111, 5'b00000, 1, 5'b01111, 1, 5'b11111, 5'b11111, 0, 4);
    // flush[2] on a held full pipe
    add(1, 5'b11111, 5'b00100, 0, 5'b11111, 0, 5'b00000, 5'b00000, 1, 5);
    add(0, 5'b11111, 5'b00000, 0, 5'b11100, 1, 5'b00000, 5'b00011, 1, 3);
    // flush[4] while the oldest retires
    add(1, 5'b11111, 5'b10000, 1, 5'b11100, 0, 5'b00000, 5'b11111, 1, 3);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 1, 5'b00000, 5'b11111, 0, 0);
    // flush[0] drops only the incoming offer
    add(1, 5'b11111, 5'b00001, 1, 5'b00000, 0, 5'b00000, 5'b11111, 0, 0);
    add(1, 5'b11111, 5'b00000, 1, 5'b00000, 1, 5'b00001, 5'b11111, 0, 0);
    add(0, 5'b11111, 5'b00000, 1, 5'b00001, 1, 5'b00010, 5'b11111, 0, 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].iv, vecs[k].rg, vecs[k].fl, vecs[k].ordy);
      #1;
      check($sformatf("v%0d stage_valid", k),   32'(stage_valid),   32'(vecs[k].e_valid));
      check($sformatf("v%0d in_ready", k),      32'(in_ready),      32'(vecs[k].e_in_ready));
      check($sformatf("v%0d stage_load", k),    32'(stage_load),    32'(vecs[k].e_load));
      check($sformatf("v%0d stage_allowin", k), 32'(stage_allowin), 32'(vecs[k].e_allowin));
      check($sformatf("v%0d out_valid", k),     32'(out_valid),     32'(vecs[k].e_out_valid));
      check($sformatf("v%0d occupancy", k),     occupancy,          32'(vecs[k].e_occ));
      @(negedge clk);
    end

    // asynchronous reset between clock edges while streaming (state 00010 -> 10111)
    drive(1'b1, '1, '0, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset occupancy", occupancy, 32'd4);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset stage_valid", 32'(stage_valid), 32'd0);
    check("async_reset out_valid",   32'(out_valid),   32'd0);
    check("async_reset occupancy",   occupancy,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset in_ready",   32'(in_ready),      32'd1);
    check("post_reset stage_load", 32'(stage_load),    32'd1);
    check("post_reset allowin",    32'(stage_allowin), 32'h1f);
    @(negedge clk);
    #1;
    check("post_reset stage_valid", 32'(stage_valid), 32'd1);

`ifdef PIPE_HANDSHAKE_PERF_EN
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("perf_retired reset", perf_retired, 32'd0);
    check("perf_bubble reset",  perf_bubble,  32'd0);
    check("perf_flush reset",   perf_flush,   32'd0);
    @(negedge clk);
    rst = 1'b0;
    mv = '0;
    exp_ret = 0; exp_bub = 0; exp_fl = 0;
    for (int c = 0; c < 1000; c++) begin
      logic         iv, ordy;
      logic [S-1:0] rg, fl;
      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < S; b++) rg[b] = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      drive(iv, rg, fl, ordy);
      ma[S] = ordy;
      for (int b = S - 1; b >= 0; b--) ma[b] = !mv[b] | (rg[b] & ma[b+1]);
      mk[S-1] = 1'b0;
      for (int b = S - 2; b >= 0; b--) mk[b] = mk[b+1] | fl[b+1];
      for (int b = 0; b < S; b++) begin
        if (mk[b]) nv[b] = 1'b0;
        else if (ma[b]) nv[b] = (b == 0) ? (iv & !(|fl)) : (mv[b-1] & rg[b-1] & !mk[b-1]);
        else nv[b] = mv[b];
      end
      if (mv[S-1] && rg[S-1] && ordy) exp_ret++;
      if (!mv[S-1]) exp_bub++;
      if (|fl[S-1:1]) exp_fl++;
      #1;
      check($sformatf("rand%0d stage_valid", c), 32'(stage_valid), 32'(mv));
      mv = nv;
      @(negedge clk);
    end
    #1;
    check("perf_retired count", perf_retired, 32'(exp_ret));
    check("perf_bubble count",  perf_bubble,  32'(exp_bub));
    check("perf_flush count",   perf_flush,   32'(exp_fl));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
